ps2_combat_ctrl: RTL and testbench

Parametrised successor to the keyboard-driven health block. It oversamples the PS/2 keyboard lines in the system clock domain, decodes and parity-checks 11-bit frames, and tracks make/break/extended prefixes. It maps keys to combat actions, runs a periodic CPU counter-attack, and keeps two saturating health counters. Both are shown as thermometer LED bars, and the block latches a game-over/winner result.

---
 rtl/ps2_combat_ctrl_if.sv | 30 +++
 rtl/ps2_combat_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ps2_combat_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_combat_ctrl_if.sv
// ps2_combat_ctrl_if: PS/2 pins toward the controller, decoded keys and
// game status (health bars, shield, result) back out. slave = controller.
interface ps2_combat_ctrl_if #(
  parameter int HEALTH_W = 10
);
  logic                clk_kb;
  logic                data_kb;
  logic                key_valid;
  logic [7:0]          key_code;
  logic                frame_err;
  logic [HEALTH_W-1:0] cpu_led;
  logic [HEALTH_W-1:0] player_led;
  logic                shield;
  logic                game_over;
  logic                winner;

  modport slave (
    input  clk_kb, data_kb,
    output key_valid, key_code, frame_err,
    output cpu_led, player_led,
    output shield, game_over, winner
  );

  modport master (
    output clk_kb, data_kb,
    input  key_valid, key_code, frame_err,
    input  cpu_led, player_led,
    input  shield, game_over, winner
  );
endinterface

// File: rtl/ps2_combat_ctrl.sv
// ps2_combat_ctrl: PS/2 keyboard decoder driving a two-sided combat game.
// Ports: clk, reset (sync, high), bus (slave: PS/2 in, keys/health/result out).
module ps2_combat_ctrl #(
  parameter int HEALTH_W    = 10,
  parameter int LIGHT_DMG   = 1,
  parameter int HEAVY_DMG   = 3,
  parameter int CPU_DMG     = 2,
  parameter int CPU_PERIOD  = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_combat_ctrl_if.slave   bus
);
  localparam int HP_W = $clog2(HEALTH_W + 1);
  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int AC_W = $clog2(CPU_PERIOD);

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_LIGHT = 8'h1C;
  localparam logic [7:0] K_HEAVY = 8'h23;
  localparam logic [7:0] K_BLOCK = 8'h29;
  localparam logic [7:0] K_ENTER = 8'h5A;

  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HEALTH_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } frm_e;

  logic kbc_s1_q, kbc_s2_q;
  logic kbd_s1_q, kbd_s2_q;

  logic            filt_q, filt_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            strobe;

  frm_e            st_q, st_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shf_q, shf_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            kv_q, kv_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      code_q, code_d;

  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic            make;

  logic            act_light, act_heavy;
  logic            act_block, act_enter;

  logic [HP_W-1:0] cpu_q, cpu_d;
  logic [HP_W-1:0] ply_q, ply_d;
  logic            shield_q, shield_d;
  logic            go_q, go_d;
  logic            win_q, win_d;
  logic [AC_W-1:0] acnt_q, acnt_d;
  logic            fire;

  logic [HEALTH_W-1:0] cpu_led, ply_led;

  function automatic logic [HP_W-1:0] sat_sub(
    input logic [HP_W-1:0] a,
    input int              d
  );
    if (int'(a) > d) sat_sub = a - HP_W'(d);
    else             sat_sub = '0;
  endfunction

  // Glitch filter: level flips only after FILTER_LEN
  // consecutive disagreeing samples; a 1->0 flip is a strobe.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    strobe = 1'b0;
    if (kbc_s2_q != filt_q) begin
      if (fcnt_q == FC_W'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        strobe = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    par_d  = par_q;
    wd_d   = '0;
    kv_d   = 1'b0;
    ferr_d = 1'b0;
    code_d = code_q;
    if (st_q != S_IDLE && !strobe) begin
      wd_d = wd_q + 1'b1;
    end
    if (strobe) begin
      unique case (st_q)
        S_IDLE: begin
          if (!kbd_s2_q) begin
            st_d  = S_DATA;
            bit_d = '0;
          end
        end
        S_DATA: begin
          shf_d = {kbd_s2_q, shf_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = S_PARITY;
        end
        S_PARITY: begin
          par_d = kbd_s2_q;
          st_d  = S_STOP;
        end
        S_STOP: begin
          st_d = S_IDLE;
          if (kbd_s2_q && (^{shf_q, par_q})) begin
            kv_d   = 1'b1;
            code_d = shf_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end else if (st_q != S_IDLE &&
                 wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      st_d   = S_IDLE;
      ferr_d = 1'b1;
      wd_d   = '0;
    end
  end

  // Prefixes arm a flag for the next code; only an
  // unprefixed code counts as a make.
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    make  = 1'b0;
    if (kv_q) begin
      if (code_q == K_BRK) begin
        brk_d = 1'b1;
      end else if (code_q == K_EXT) begin
        ext_d = 1'b1;
      end else begin
        make  = !brk_q && !ext_q;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_comb begin
    act_light = 1'b0;
    act_heavy = 1'b0;
    act_block = 1'b0;
    act_enter = 1'b0;
    if (make) begin
      unique case (1'b1)
        code_q == K_LIGHT: act_light = 1'b1;
        code_q == K_HEAVY: act_heavy = 1'b1;
        code_q == K_BLOCK: act_block = 1'b1;
        code_q == K_ENTER: act_enter = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_d    = cpu_q;
    ply_d    = ply_q;
    shield_d = shield_q;
    go_d     = go_q;
    win_d    = win_q;
    acnt_d   = acnt_q;
    fire     = 1'b0;
    if (go_q) begin
      if (act_enter) begin
        cpu_d    = HP_FULL;
        ply_d    = HP_FULL;
        shield_d = 1'b0;
        go_d     = 1'b0;
        win_d    = 1'b0;
        acnt_d   = '0;
      end
    end else begin
      fire   = (acnt_q == AC_W'(CPU_PERIOD - 1));
      acnt_d = fire ? '0 : acnt_q + 1'b1;
      if (act_light) cpu_d = sat_sub(cpu_q, LIGHT_DMG);
      if (act_heavy) cpu_d = sat_sub(cpu_q, HEAVY_DMG);
      if (fire && !shield_q) ply_d = sat_sub(ply_q, CPU_DMG);
      // Attack consumes the old shield; a block in
      // the same cycle re-arms it.
      if (act_block) shield_d = 1'b1;
      else if (fire) shield_d = 1'b0;
      // Player wins a simultaneous knockout.
      if (cpu_q == '0 || ply_q == '0) begin
        go_d  = 1'b1;
        win_d = (cpu_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbc_s1_q <= 1'b1;
      kbc_s2_q <= 1'b1;
      kbd_s1_q <= 1'b1;
      kbd_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      st_q     <= S_IDLE;
      bit_q    <= '0;
      shf_q    <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      kv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      code_q   <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      cpu_q    <= HP_FULL;
      ply_q    <= HP_FULL;
      shield_q <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
      acnt_q   <= '0;
    end else begin
      kbc_s1_q <= bus.clk_kb;
      kbc_s2_q <= kbc_s1_q;
      kbd_s1_q <= bus.data_kb;
      kbd_s2_q <= kbd_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      st_q     <= st_d;
      bit_q    <= bit_d;
      shf_q    <= shf_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      kv_q     <= kv_d;
      ferr_q   <= ferr_d;
      code_q   <= code_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      cpu_q    <= cpu_d;
      ply_q    <= ply_d;
      shield_q <= shield_d;
      go_q     <= go_d;
      win_q    <= win_d;
      acnt_q   <= acnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < HEALTH_W; i++) begin
      cpu_led[i] = (int'(cpu_q) > i);
      ply_led[i] = (int'(ply_q) > i);
    end
  end

  assign bus.key_valid  = kv_q;
  assign bus.key_code   = code_q;
  assign bus.frame_err  = ferr_q;
  assign bus.cpu_led    = cpu_led;
  assign bus.player_led = ply_led;
  assign bus.shield     = shield_q;
  assign bus.game_over  = go_q;
  assign bus.winner     = win_q;
endmodule

// File: tb/tb_ps2_combat_ctrl.sv
// tb_ps2_combat_ctrl: bit-banged PS/2 frames against a game-rule model,
// checked every cycle, plus literal expectations per scenario.
module tb_ps2_combat_ctrl;
  localparam int HW  = 10;
  localparam int LD  = 1;
  localparam int HD  = 3;
  localparam int CD  = 2;
  localparam int PER = 1500;
  localparam int FL  = 4;
  localparam int TO  = 200;
  localparam int H   = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_combat_ctrl_if #(.HEALTH_W(HW)) bus ();

  ps2_combat_ctrl #(
    .HEALTH_W(HW), .LIGHT_DMG(LD), .HEAVY_DMG(HD),
    .CPU_DMG(CD), .CPU_PERIOD(PER), .FILTER_LEN(FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int m_cpu, m_ply, m_cnt;
  bit m_sh, m_go, m_win, m_brk, m_ext;
  bit armed = 1'b0;
  bit pend = 1'b0;
  logic [7:0] pend_code, m_code;

  logic [7:0] exp_code [64];
  int wr_idx = 0;
  int rd_idx = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  int kv_cyc = 0;
  int fall_cyc = 0;
  int t0 = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Game rules applied per clock, in spec terms.
  task automatic model_step();
    bit make, fire;
    logic [7:0] c;
    int nc, np;
    cyc++;
    if (reset) begin
      m_cpu = HW; m_ply = HW; m_cnt = 0;
      m_sh = 0; m_go = 0; m_win = 0;
      m_brk = 0; m_ext = 0; m_code = 8'h00;
      pend = 0; rd_idx = wr_idx; armed = 1;
    end else begin
      make = 0;
      c = pend_code;
      if (pend) begin
        if (c == 8'hF0) m_brk = 1;
        else if (c == 8'hE0) m_ext = 1;
        else begin
          make = !m_brk && !m_ext;
          m_brk = 0; m_ext = 0;
        end
      end
      pend = 0;
      if (m_go) begin
        if (make && c == 8'h5A) begin
          m_cpu = HW; m_ply = HW; m_cnt = 0;
          m_sh = 0; m_go = 0; m_win = 0;
        end
      end else begin
        fire = (m_cnt == PER - 1);
        nc = m_cpu;
        np = m_ply;
        if (make && c == 8'h1C) nc -= LD;
        if (make && c == 8'h23) nc -= HD;
        if (fire && !m_sh) np -= CD;
        if (m_cpu == 0 || m_ply == 0) begin
          m_go = 1;
          m_win = (m_cpu == 0);
        end
        if (make && c == 8'h29) m_sh = 1;
        else if (fire) m_sh = 0;
        m_cpu = (nc < 0) ? 0 : nc;
        m_ply = (np < 0) ? 0 : np;
        m_cnt = (m_cnt + 1) % PER;
      end
    end
  endtask

  task automatic monitor_cmp();
    if (armed) begin
      chk("cpu_led", 32'(bus.cpu_led), (1 << m_cpu) - 1);
      chk("player_led", 32'(bus.player_led), (1 << m_ply) - 1);
      chk("shield", 32'(bus.shield), 32'(m_sh));
      chk("game_over", 32'(bus.game_over), 32'(m_go));
      chk("winner", 32'(bus.winner), 32'(m_win));
      if (bus.key_valid === 1'b1) begin
        kv_cnt++;
        kv_cyc = cyc;
        if (rd_idx == wr_idx) begin
          tests++;
          fails++;
          $display("FAIL key_valid: unexpected pulse code %0h, want none",
                   bus.key_code);
        end else begin
          m_code = exp_code[rd_idx % 64];
          pend = 1;
          pend_code = m_code;
          rd_idx++;
        end
      end
      chk("key_code", 32'(bus.key_code), 32'(m_code));
      if (bus.frame_err === 1'b1) err_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
  endtask

  // Bits go out start, data LSB first, odd parity, stop.
  task automatic send(input logic [7:0] code, input bit bad,
                      input int nbits);
    logic [10:0] b;
    b = {1'b1, (~^code) ^ bad, code, 1'b0};
    if (!bad && nbits == 11) begin
      exp_code[wr_idx % 64] = code;
      wr_idx++;
    end
    for (int i = 0; i < nbits; i++) begin
      bus.data_kb = b[i];
      repeat (H) @(negedge clk);
      bus.clk_kb = 1'b0;
      if (i == 10) fall_cyc = cyc;
      repeat (H) @(negedge clk);
      bus.clk_kb = 1'b1;
    end
    bus.data_kb = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  initial begin
    int k0, e0, g, lat, cw, d;
    logic [31:0] heavy_led [4];
    heavy_led[0] = 32'h07F;
    heavy_led[1] = 32'h00F;
    heavy_led[2] = 32'h001;
    heavy_led[3] = 32'h000;
    bus.clk_kb = 1'b1;
    bus.data_kb = 1'b1;
    fork
      forever begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        monitor_cmp();
      end
    join_none

    // Reset state and a single light attack.
    do_reset();
    chk("rst_cpu_led", 32'(bus.cpu_led), 32'h3FF);
    chk("rst_player_led", 32'(bus.player_led), 32'h3FF);
    chk("rst_key_code", 32'(bus.key_code), 32'h00);
    k0 = kv_cnt; e0 = err_cnt;
    send(8'h1C, 1'b0, 11);
    chk("s1_kv", kv_cnt - k0, 1);
    chk("s1_code", 32'(bus.key_code), 32'h1C);
    chk("s1_cpu_led", 32'(bus.cpu_led), 32'h1FF);
    chk("s1_err", err_cnt - e0, 0);

    // Heavy attacks down to zero; player wins.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'h23, 1'b0, 11);
      chk("s2_cpu_led", 32'(bus.cpu_led), heavy_led[i]);
    end
    chk("s2_game_over", 32'(bus.game_over), 1);
    chk("s2_winner", 32'(bus.winner), 1);
    k0 = kv_cnt;
    send(8'h1C, 1'b0, 11);
    chk("s2_kv_frozen", kv_cnt - k0, 1);
    chk("s2_cpu_frozen", 32'(bus.cpu_led), 32'h000);

    // Break and extended prefixes suppress the action.
    do_reset();
    k0 = kv_cnt;
    send(8'hF0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    send(8'hE0, 1'b0, 11);
    send(8'h1C, 1'b0, 11);
    chk("s3_kv", kv_cnt - k0, 4);
    chk("s3_cpu_led", 32'(bus.cpu_led), 32'h3FF);
    send(8'h1C, 1'b0, 11);
    chk("s3_cpu_make", 32'(bus.cpu_led), 32'h1FF);

    // Parity error and watchdog timeout, then recovery.
    do_reset();
    k0 = kv_cnt; e0 = err_cnt;
    send(8'h1C, 1'b1, 11);
    send(8'h1C, 1'b0, 5);
    repeat (TO + 50) @(negedge clk);
    chk("s4_err", err_cnt - e0, 2);
    chk("s4_kv_none", kv_cnt - k0, 0);
    send(8'h23, 1'b0, 11);
    chk("s4_kv_good", kv_cnt - k0, 1);
    chk("s4_code", 32'(bus.key_code), 32'h23);
    chk("s4_cpu_led", 32'(bus.cpu_led), 32'h07F);

    // Block absorbs the first CPU attack only.
    do_reset();
    send(8'h29, 1'b0, 11);
    chk("s5_shield_on", 32'(bus.shield), 1);
    while (cyc - t0 < 1600) @(negedge clk);
    chk("s5_shield_used", 32'(bus.shield), 0);
    chk("s5_ply_full", 32'(bus.player_led), 32'h3FF);
    while (cyc - t0 < 3200) @(negedge clk);
    chk("s5_ply_8", 32'(bus.player_led), 32'h0FF);

    // Simultaneous knockout, then Enter restarts.
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h23, 1'b0, 11);
    lat = kv_cyc - fall_cyc;
    chk("s6_cpu_1", 32'(bus.cpu_led), 32'h001);
    g = 0;
    while (m_ply != 2 && g < 8000) begin
      @(negedge clk);
      g++;
    end
    chk("s6_ply_2", 32'(bus.player_led), 32'h003);
    cw = cyc + (PER - 1 - m_cnt);
    d = cw - lat - 21 * H - cyc;
    if (d > 0) repeat (d) @(negedge clk);
    send(8'h1C, 1'b0, 11);
    repeat (5) @(negedge clk);
    chk("s6_game_over", 32'(bus.game_over), 1);
    chk("s6_winner", 32'(bus.winner), 1);
    chk("s6_cpu_zero", 32'(bus.cpu_led), 32'h000);
    chk("s6_ply_zero", 32'(bus.player_led), 32'h000);
    send(8'h5A, 1'b0, 11);
    repeat (5) @(negedge clk);
    chk("s6_cpu_restart", 32'(bus.cpu_led), 32'h3FF);
    chk("s6_ply_restart", 32'(bus.player_led), 32'h3FF);
    chk("s6_go_clear", 32'(bus.game_over), 0);
    chk("keys_drained", 32'(rd_idx), 32'(wr_idx));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
